mac_accumulator: RTL

//  Accumulate stage of the 16-bit MAC unit, directly downstream of mul_16x16.

---
 rtl/mac_pkg.sv | 19 +
 rtl/adder_40bit.sv | 16 +
 rtl/mac_accumulator.sv | 92 +++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate stage: FSM state encoding and accumulator width.
package mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int unsigned PROD_W_DEF  = 32;
   localparam int unsigned GUARD_W_DEF = 8;
   localparam int unsigned CNT_W_DEF   = 8;

   // Accumulator is the product width plus guard bits for headroom
   function automatic int unsigned acc_width(input int unsigned prod_w, input int unsigned guard_w);
      return prod_w + guard_w;
   endfunction

endpackage

// File: rtl/adder_40bit.sv
// Ripple-free behavioural adder with carry-in/carry-out; W defaults to 40 bits.
module adder_40bit #(
   parameter int unsigned W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int unsigned SW = W + 1;

   assign {cout, sum} = SW'(a) + SW'(b) + SW'(cin);

endmodule

// File: rtl/mac_accumulator.sv
// Accumulate stage of the 16-bit MAC: sums a frame of len products and holds the
// result under a valid/ready handshake, stalling the product stream until it is taken.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter  int unsigned PROD_W  = PROD_W_DEF,
   parameter  int unsigned GUARD_W = GUARD_W_DEF,
   parameter  int unsigned CNT_W   = CNT_W_DEF,
   localparam int unsigned ACC_W   = acc_width(PROD_W, GUARD_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic              busy,
   output logic              overflow
);

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [ACC_W-1:0]   acc_d, sum;
   logic               ovf_d, cout, beat;
   logic               prod_ready_d, acc_valid_d, busy_d;

   assign beat = prod_valid & prod_ready;

   adder_40bit #(.W(ACC_W)) u_adder (
      .a    (acc_out),
      .b    (ACC_W'(prod)),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // State, counter, accumulator and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         acc_out    <= '0;
         overflow   <= 1'b0;
         prod_ready <= 1'b0;
         acc_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= next_state;
         cnt        <= cnt_d;
         acc_out    <= acc_d;
         overflow   <= ovf_d;
         prod_ready <= prod_ready_d;
         acc_valid  <= acc_valid_d;
         busy       <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (start) next_state = (len != '0) ? ST_ACC : ST_HOLD;
         ST_ACC:  if (beat && cnt == CNT_W'(1)) next_state = ST_HOLD;
         ST_HOLD: if (acc_valid && acc_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Datapath and output next values; status outputs decode the next state so they are registered
   always_comb begin
      acc_d        = acc_out;
      ovf_d        = overflow;
      cnt_d        = cnt;
      prod_ready_d = (next_state == ST_ACC);
      acc_valid_d  = (next_state == ST_HOLD);
      busy_d       = (next_state != ST_IDLE);
      if (state == ST_IDLE && start) begin
         acc_d = '0;
         ovf_d = 1'b0;
         cnt_d = len;
      end else if (state == ST_ACC && beat) begin
         acc_d = sum;
         ovf_d = overflow | cout;
         cnt_d = cnt - CNT_W'(1);
      end
   end

endmodule
